mole_game_ctrl: RTL and testbench

Game controller for WHACK-A-MOLE on BASYS 3, directly downstream of the 2-bit mole counter. It takes the counter's mole position, drives one of four mole LEDs, and synchronises and edge-detects the four whack buttons. It scores hits and misses in two-digit BCD for the display stage, and ends the round after a fixed number of moles.

---
 rtl/mole_game_ctrl.sv | 139 +++++++++++++
 tb/tb_mole_game_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: conditions start/whack buttons, lights the
// current mole, keeps BCD hit/miss scores and counts down the moles in a round.
module mole_game_ctrl #(
  parameter int unsigned ROUND_MOLES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [1:0] mole_pos,
  output logic [3:0] led,
  output logic [7:0] score_bcd,
  output logic [7:0] miss_bcd,
  output logic [7:0] moles_left,
  output logic       playing,
  output logic       game_over
);

  // state | meaning
  // IDLE  | power-up, waiting for start; LEDs dark
  // PLAY  | round running; moles shown and whacks scored
  // OVER  | round finished; all LEDs lit, results frozen until start
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [7:0] ROUND_INIT = 8'(ROUND_MOLES);

  state_t     state_q, state_d;
  logic       start_s1, start_s2, start_prev;
  logic [3:0] btn_s1, btn_s2, btn_prev;
  logic [1:0] pos_q;
  logic       hit_q, hit_d;
  logic [7:0] score_q, score_d;
  logic [7:0] miss_q, miss_d;
  logic [7:0] left_q, left_d;
  logic [3:0] led_q, led_d;

  logic       start_pulse;
  logic [3:0] btn_pulse;
  logic       mole_change;
  logic [3:0] pos_onehot;
  logic       hit_press;
  logic [3:0] wrong;
  logic [1:0] miss_n;

  // Saturating BCD add: value + n clamped to 99, re-encoded as two digits.
  function automatic logic [7:0] bcd_add(input logic [7:0] v, input logic [1:0] n);
    logic [7:0] sum;
    sum = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]) + 8'(n);
    if (sum > 8'd99) sum = 8'd99;
    return {4'(sum / 8'd10), 4'(sum % 8'd10)};
  endfunction

  assign start_pulse = start_s2 & ~start_prev;
  assign btn_pulse   = btn_s2 & ~btn_prev;
  assign mole_change = (mole_pos != pos_q);
  assign pos_onehot  = 4'b0001 << pos_q;
  assign hit_press   = |(btn_pulse & pos_onehot) & ~hit_q;
  assign wrong       = btn_pulse & ~pos_onehot;
  assign miss_n      = {1'b0, wrong[0]} + {1'b0, wrong[1]} + {1'b0, wrong[2]} + {1'b0, wrong[3]};

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    miss_d  = miss_q;
    left_d  = left_q;
    hit_d   = hit_q & ~mole_change;
    led_d   = 4'h0;
    case (state_q)
      IDLE, OVER: begin
        if (start_pulse) begin
          score_d = 8'h00;
          miss_d  = 8'h00;
          left_d  = ROUND_INIT;
          hit_d   = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        // Presses are judged against the mole shown this cycle, even on a change.
        if (hit_press) begin
          score_d = bcd_add(score_q, 2'd1);
          hit_d   = ~mole_change;
        end
        if (|wrong) miss_d = bcd_add(miss_q, miss_n);
        if (mole_change) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
    // LEDs are registered from next-cycle values so they track pos_q/hit_done.
    case (state_d)
      PLAY:    led_d = hit_d ? 4'h0 : (4'b0001 << mole_pos);
      OVER:    led_d = 4'hF;
      default: led_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      btn_s1     <= 4'h0;
      btn_s2     <= 4'h0;
      btn_prev   <= 4'h0;
      pos_q      <= 2'd0;
      hit_q      <= 1'b0;
      score_q    <= 8'h00;
      miss_q     <= 8'h00;
      left_q     <= 8'h00;
      led_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
      btn_prev   <= btn_s2;
      pos_q      <= mole_pos;
      hit_q      <= hit_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      left_q     <= left_d;
      led_q      <= led_d;
    end
  end

  assign led        = led_q;
  assign score_bcd  = score_q;
  assign miss_bcd   = miss_q;
  assign moles_left = left_q;
  assign playing    = (state_q == PLAY);
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Scoreboard bench for mole_game_ctrl: directed stimulus queues expected output
// snapshots tagged with a due cycle; a negedge monitor pops and compares them.
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] btn;
  logic [1:0] mole_pos;

  logic [3:0] a_led, b_led;
  logic [7:0] a_score, a_miss, a_left, b_score, b_miss, b_left;
  logic       a_play, a_over, b_play, b_over;

  mole_game_ctrl #(.ROUND_MOLES(105)) dut_a (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .mole_pos(mole_pos),
    .led(a_led), .score_bcd(a_score), .miss_bcd(a_miss), .moles_left(a_left),
    .playing(a_play), .game_over(a_over));

  mole_game_ctrl #(.ROUND_MOLES(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .mole_pos(mole_pos),
    .led(b_led), .score_bcd(b_score), .miss_bcd(b_miss), .moles_left(b_left),
    .playing(b_play), .game_over(b_over));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         sel;
    string      name;
    logic [3:0] led;
    logic [7:0] score, miss, left;
    logic       play, over;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] e_led;
  logic [7:0] e_score, e_miss, e_left;
  logic       e_play, e_over;
  bit         cur_sel;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] oh(input int p);
    logic [3:0] r;
    r = 4'b0001 << (p % 4);
    return r;
  endfunction

  task automatic push(input int d, input string nm);
    exp_t e;
    e.due = cyc + d; e.sel = cur_sel; e.name = nm;
    e.led = e_led; e.score = e_score; e.miss = e_miss; e.left = e_left;
    e.play = e_play; e.over = e_over;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input string nm);
    btn = m;
    push(3, nm);
    tick; tick;
    btn = 4'h0;
    repeat (3) tick;
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    push(3, nm);
    tick; tick;
    start = 1'b0;
    repeat (3) tick;
  endtask

  task automatic clear_exp;
    e_led = 4'h0; e_score = 8'h00; e_miss = 8'h00; e_left = 8'h00;
    e_play = 1'b0; e_over = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] l;
    logic [7:0] s, m, ml;
    logic       p, o;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.sel) begin l = b_led; s = b_score; m = b_miss; ml = b_left; p = b_play; o = b_over; end
      else       begin l = a_led; s = a_score; m = a_miss; ml = a_left; p = a_play; o = a_over; end
      checks++;
      if (e.due != cyc || l !== e.led || s !== e.score || m !== e.miss || ml !== e.left ||
          p !== e.play || o !== e.over) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got led=%b score=%h miss=%h left=%0d play=%b over=%b want led=%b score=%h miss=%h left=%0d play=%b over=%b",
                 e.name, cyc, e.due, l, s, m, ml, p, o, e.led, e.score, e.miss, e.left, e.play, e.over);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; btn = 4'h0; mole_pos = 2'd0; cur_sel = 1'b0;
    clear_exp();
    tick; tick;
    checks++;
    if (a_led !== 4'h0 || a_score !== 8'h00 || a_miss !== 8'h00 || a_left !== 8'h00 ||
        a_play !== 1'b0 || a_over !== 1'b0 || b_led !== 4'h0 || b_left !== 8'h00 ||
        b_play !== 1'b0 || b_over !== 1'b0) begin
      errors++;
      $display("FAIL direct_reset a_led=%b a_score=%h a_left=%0d b_left=%0d", a_led, a_score, a_left, b_left);
    end
    rst = 1'b0;
    push(0, "reset");
    for (int k = 0; k < 10; k++) begin
      mole_pos = 2'(k);
      push(1, "idle_led");
      repeat (10) tick;
    end

    // correct hit on mole 2, then a repeat press on the same mole
    mole_pos = 2'd2; tick;
    e_play = 1'b1; e_left = 8'd105; e_led = 4'b0100;
    do_start("start");
    e_score = 8'h01; e_led = 4'h0;
    press(4'b0100, "hit");
    press(4'b0100, "rehit");

    // wrong buttons on mole 1, then all four at once
    mole_pos = 2'd1; e_left = 8'd104; e_led = 4'b0010;
    push(1, "mole_change");
    tick;
    e_miss = 8'h02;
    press(4'b1001, "wrong2");
    e_score = 8'h02; e_miss = 8'h05; e_led = 4'h0;
    press(4'b1111, "mixed");

    // build score 5, then reset mid-play
    rst = 1'b1; tick; rst = 1'b0;
    mole_pos = 2'd0; tick;
    clear_exp();
    e_play = 1'b1; e_left = 8'd105; e_led = 4'b0001;
    do_start("restart");
    for (int i = 1; i <= 5; i++) begin
      mole_pos = 2'(i); tick;
      e_score = bcd(i); e_left = 8'(105 - i); e_led = 4'h0;
      press(oh(i), $sformatf("hit%0d", i));
    end
    rst = 1'b1;
    clear_exp();
    push(1, "rst_mid");
    tick;
    rst = 1'b0;

    // fresh round: score saturation, then miss saturation
    e_play = 1'b1; e_left = 8'd105; e_led = 4'b0010;
    do_start("fresh_start");
    for (int i = 1; i <= 100; i++) begin
      mole_pos = 2'(i + 1); tick;
      e_score = (i > 99) ? 8'h99 : bcd(i); e_left = 8'(105 - i); e_led = 4'h0;
      press(oh(i + 1), $sformatf("sat%0d", i));
    end
    for (int k = 1; k <= 34; k++) begin
      e_miss = (3 * k > 99) ? 8'h99 : bcd(3 * k);
      press(4'b1101, $sformatf("msat%0d", k));
    end

    // round end on the 4-mole instance
    cur_sel = 1'b1;
    rst = 1'b1; tick; rst = 1'b0;
    mole_pos = 2'd0; tick;
    clear_exp();
    e_play = 1'b1; e_left = 8'd4; e_led = 4'b0001;
    do_start("b_start");
    for (int m = 1; m <= 3; m++) begin
      mole_pos = 2'(m);
      e_left = 8'(4 - m); e_led = oh(m);
      push(1, $sformatf("b_change%0d", m));
      tick;
    end
    btn = 4'b0001;
    tick; tick;
    mole_pos = 2'd0;
    e_left = 8'd0; e_miss = 8'h01; e_led = 4'hF; e_play = 1'b0; e_over = 1'b1;
    push(1, "b_final");
    tick;
    btn = 4'h0;
    repeat (3) tick;
    press(4'b0001, "b_over_btn");
    e_play = 1'b1; e_over = 1'b0; e_left = 8'd4; e_miss = 8'h00; e_score = 8'h00; e_led = 4'b0001;
    do_start("b_restart");

    repeat (5) tick;
    checks++;
    if (b_play !== 1'b1 || b_over !== 1'b0 || b_left !== 8'd4 || b_score !== 8'h00 ||
        b_miss !== 8'h00 || b_led !== 4'b0001) begin
      errors++;
      $display("FAIL direct_b_restart play=%b over=%b left=%0d score=%h miss=%h led=%b",
               b_play, b_over, b_left, b_score, b_miss, b_led);
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never checked due=%0d cyc=%0d", e.name, e.due, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0) $display("FAIL");
    else             $display("PASS");
    $finish;
  end

endmodule
